seg_display_driver: RTL and testbench

- Parameterised binary-to-seven-segment display driver for the DE1-SoC HEX bank. Fed from the CPU's memory-mapped out_port registers.
- Replaces the combinational %10 / /10 per-port split with a sequential double-dabble converter, so any WIDTH and any digit count are supported.
- Adds a start/busy/done handshake, a hex mode, leading-zero blanking and overflow indication.
- Segment outputs are active-low (common anode).

---
 rtl/seg_display_driver_if.sv | 27 ++
 rtl/seg_display_driver.sv | 227 ++++++++++++++++++++++
 tb/tb_seg_display_driver.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/seg_display_driver_if.sv
// seg_display_driver_if: request/result bundle between the CPU out_port
// logic (master) and the seven-segment driver (slave).
interface seg_display_driver_if #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 6
);
   logic                  start;
   logic [WIDTH-1:0]      value;
   logic                  hex_mode;
   logic                  blank_lz;
   logic                  busy;
   logic                  done;
   logic                  ovf;
   logic                  neg;
   logic [4*DIGITS-1:0]   bcd;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output start, value, hex_mode, blank_lz,
      input  busy, done, ovf, neg, bcd, seg
   );

   modport slave (
      input  start, value, hex_mode, blank_lz,
      output busy, done, ovf, neg, bcd, seg
   );
endinterface

// File: rtl/seg_display_driver.sv
// seg_display_driver: binary to seven-segment driver for the DE1-SoC HEX bank.
// Decimal digits come from a sequential double-dabble converter (WIDTH shift
// cycles), hex digits are taken straight from the value nibbles.
// Segments are gfedcba, active-low; digit 0 is the rightmost.
// Optional macro DISP_SIGNED_EN: treat value as two's complement in decimal
// mode and show a leading minus sign.
module seg_display_driver #(
   parameter int WIDTH  = 32,
   parameter int DIGITS = 6
) (
   input  logic                  clock,
   input  logic                  reset,
   seg_display_driver_if.slave   bus
);

   localparam int BW   = 4 * DIGITS;
   localparam int SW   = 7 * DIGITS;
   localparam int PADW = (WIDTH > BW) ? WIDTH : BW;
   localparam int CW   = $clog2(WIDTH + 1);

   localparam logic [6:0] SEG_DASH  = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   bin_q, bin_d;
   logic [BW-1:0]      work_q, work_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               wovf_q, wovf_d;
   logic               wneg_q, wneg_d;
   logic               blank_q, blank_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               ovf_q, ovf_d;
   logic               neg_q, neg_d;
   logic [BW-1:0]      bcd_q, bcd_d;
   logic [SW-1:0]      seg_q, seg_d;

   // accept-time values
   logic [WIDTH-1:0]   mag;
   logic               sgn;
   logic [PADW-1:0]    pad;
   logic               hex_ovf;

   // double-dabble step
   logic [BW-1:0]      corr;

   // final display
   logic [SW-1:0]      disp;
   logic               fovf;
   int                 msnz;
   int                 minus_pos;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Magnitude, sign and hex view of the incoming value
   always_comb begin
      mag = bus.value;
      sgn = 1'b0;
`ifdef DISP_SIGNED_EN
      // '0 - value also yields the right unsigned magnitude for the most
      // negative value (2^(WIDTH-1) still fits in WIDTH bits)
      if (!bus.hex_mode && bus.value[WIDTH-1]) begin
         mag = '0 - bus.value;
         sgn = 1'b1;
      end
`endif
      pad     = PADW'(bus.value);
      hex_ovf = |(pad >> BW);
   end

   // Add-3 correction on every BCD digit >= 5 ahead of the shift
   always_comb begin
      corr = work_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] >= 4'd5)
            corr[4*i +: 4] = work_q[4*i +: 4] + 4'd3;
      end
   end

   // Segment image of the finished conversion: dashes, minus, blanking
   always_comb begin
      msnz = 0;
      for (int i = 0; i < DIGITS; i++) begin
         if (work_q[4*i +: 4] != 4'd0)
            msnz = i;
      end
      // a negative value needs the top digit free for the minus sign
      fovf      = wovf_q | (wneg_q & (work_q[BW-1 -: 4] != 4'd0));
      minus_pos = blank_q ? msnz + 1 : DIGITS - 1;
      disp      = '1;
      for (int i = 0; i < DIGITS; i++) begin
         if (fovf)
            disp[7*i +: 7] = SEG_DASH;
         else if (wneg_q && (i == minus_pos))
            disp[7*i +: 7] = SEG_DASH;
         else if (blank_q && (i > msnz))
            disp[7*i +: 7] = SEG_BLANK;
         else
            disp[7*i +: 7] = seg7(work_q[4*i +: 4]);
      end
   end

   // FSM state register
   always_ff @(posedge clock) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Next state and datapath updates
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      work_d  = work_q;
      cnt_d   = cnt_q;
      wovf_d  = wovf_q;
      wneg_d  = wneg_q;
      blank_d = blank_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q;
      neg_d   = neg_q;
      bcd_d   = bcd_q;
      seg_d   = seg_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               bin_d   = mag;
               wneg_d  = sgn;
               blank_d = bus.blank_lz;
               busy_d  = 1'b1;
               cnt_d   = '0;
               if (bus.hex_mode) begin
                  work_d  = pad[BW-1:0];
                  wovf_d  = hex_ovf;
                  state_d = S_DONE;
               end else begin
                  work_d  = '0;
                  wovf_d  = 1'b0;
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            work_d = {corr[BW-2:0], bin_q[WIDTH-1]};
            bin_d  = {bin_q[WIDTH-2:0], 1'b0};
            wovf_d = wovf_q | corr[BW-1];
            cnt_d  = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1))
               state_d = S_DONE;
         end
         S_DONE: begin
            bcd_d   = work_q;
            ovf_d   = fovf;
            neg_d   = wneg_q;
            seg_d   = disp;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clock) begin
      if (reset) begin
         bin_q   <= '0;
         work_q  <= '0;
         cnt_q   <= '0;
         wovf_q  <= 1'b0;
         wneg_q  <= 1'b0;
         blank_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
         neg_q   <= 1'b0;
         bcd_q   <= '0;
         seg_q   <= '1;
      end else begin
         bin_q   <= bin_d;
         work_q  <= work_d;
         cnt_q   <= cnt_d;
         wovf_q  <= wovf_d;
         wneg_q  <= wneg_d;
         blank_q <= blank_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
         neg_q   <= neg_d;
         bcd_q   <= bcd_d;
         seg_q   <= seg_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.ovf  = ovf_q;
   assign bus.neg  = neg_q;
   assign bus.bcd  = bcd_q;
   assign bus.seg  = seg_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed and random conversions of seg_display_driver
// (WIDTH=32, DIGITS=6) checked against an arithmetic reference model.
module tb_seg_display_driver;

   localparam int WIDTH  = 32;
   localparam int DIGITS = 6;

   localparam logic [6:0] SEGT [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   seg_display_driver_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

   seg_display_driver #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Expected result computed digit by digit from the value itself
   function automatic void model(input logic [31:0] v, input bit hx, input bit bl,
                                 output logic [23:0] ebcd, output logic [41:0] eseg,
                                 output bit eovf, output bit eneg);
      longint unsigned mag;
      longint unsigned p;
      int d [DIGITS];
      int msnz;
      int mpos;
      mag  = 64'(v);
      eneg = 1'b0;
`ifdef DISP_SIGNED_EN
      if (!hx && v[31]) begin
         eneg = 1'b1;
         mag  = 64'd4294967296 - 64'(v);
      end
`endif
      if (hx) begin
         for (int i = 0; i < DIGITS; i++) d[i] = int'((v >> (4*i)) & 32'hF);
         eovf = (v >> 24) != 0;
      end else begin
         p = 1;
         for (int i = 0; i < DIGITS; i++) begin
            d[i] = int'((mag / p) % 10);
            p    = p * 10;
         end
         eovf = (mag >= 64'd1000000) || (eneg && mag >= 64'd100000);
      end
      msnz = 0;
      for (int i = 0; i < DIGITS; i++) if (d[i] != 0) msnz = i;
      mpos = bl ? msnz + 1 : DIGITS - 1;
      ebcd = '0;
      eseg = '1;
      for (int i = 0; i < DIGITS; i++) begin
         ebcd[4*i +: 4] = 4'(d[i]);
         if (eovf)                   eseg[7*i +: 7] = 7'b0111111;
         else if (eneg && i == mpos) eseg[7*i +: 7] = 7'b0111111;
         else if (bl && i > msnz)    eseg[7*i +: 7] = 7'b1111111;
         else                        eseg[7*i +: 7] = SEGT[d[i]];
      end
   endfunction

   // One conversion: pulse start, wait for done (bounded), check everything
   task automatic run(input logic [31:0] v, input bit hx, input bit bl, input string tag);
      int cyc;
      logic [23:0] eb;
      logic [41:0] es;
      bit eo, en;
      model(v, hx, bl, eb, es, eo, en);
      @(negedge clk);
      bus.start = 1'b1; bus.value = v; bus.hex_mode = hx; bus.blank_lz = bl;
      @(negedge clk);
      bus.start = 1'b0;
      bus.value = $urandom;
      chk({tag, ".busy"}, 64'(bus.busy), 64'd1);
      cyc = 0;
      while (cyc < 100) begin
         @(negedge clk);
         cyc++;
         if (bus.done) break;
      end
      chk({tag, ".lat"}, 64'(cyc), hx ? 64'd1 : 64'(WIDTH + 1));
      chk({tag, ".bcd"}, 64'(bus.bcd), 64'(eb));
      chk({tag, ".seg"}, 64'(bus.seg), 64'(es));
      chk({tag, ".ovf"}, 64'(bus.ovf), 64'(eo));
      chk({tag, ".neg"}, 64'(bus.neg), 64'(en));
      chk({tag, ".busy0"}, 64'(bus.busy), 64'd0);
      @(negedge clk);
      chk({tag, ".pulse"}, 64'(bus.done), 64'd0);
   endtask

   initial begin
      int dcnt;
      logic [31:0] rv;
      checks = 0;
      errors = 0;
      bus.start = 1'b0; bus.value = '0; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst.busy", 64'(bus.busy), 64'd0);
      chk("rst.done", 64'(bus.done), 64'd0);
      chk("rst.ovf",  64'(bus.ovf),  64'd0);
      chk("rst.neg",  64'(bus.neg),  64'd0);
      chk("rst.bcd",  64'(bus.bcd),  64'd0);
      chk("rst.seg",  64'(bus.seg),  {22'd0, {42{1'b1}}});
      rst = 1'b0;

      // directed cases
      run(32'd123, 1'b0, 1'b0, "dec123");
      chk("dec123.const", 64'(bus.seg),
          {22'd0, 7'b1000000, 7'b1000000, 7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000});
      run(32'd7, 1'b0, 1'b1, "blank7");
      chk("blank7.const", 64'(bus.seg), {22'd0, {35{1'b1}}, 7'b1111000});
      run(32'd0, 1'b0, 1'b1, "blank0");
      run(32'd999999, 1'b0, 1'b0, "max6");
      run(32'd1000000, 1'b0, 1'b0, "ovf6");
      chk("ovf6.const", 64'(bus.seg), {22'd0, {6{7'b0111111}}});
      run(32'h0000ABCD, 1'b1, 1'b0, "hexABCD");
      run(32'h01000000, 1'b1, 1'b0, "hexovf");
      run(32'hFFFFFFFF, 1'b0, 1'b1, "allones");
`ifdef DISP_SIGNED_EN
      run(32'hFFFFFFD6, 1'b0, 1'b1, "neg42");
      run(32'hFFFE7960, 1'b0, 1'b0, "neg100k");
      run(32'h80000000, 1'b0, 1'b0, "negmin");
`endif

      // start while busy is ignored
      @(negedge clk);
      bus.start = 1'b1; bus.value = 32'd55; bus.hex_mode = 1'b0; bus.blank_lz = 1'b0;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1; bus.value = 32'd88;
      @(negedge clk);
      bus.start = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      chk("busyign.bcd",  64'(bus.bcd), 64'h55);
      chk("busyign.dcnt", 64'(dcnt), 64'd1);

      // reset mid-conversion aborts with no done
      @(negedge clk);
      bus.start = 1'b1; bus.value = 32'd4321;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort.busy", 64'(bus.busy), 64'd0);
      chk("abort.seg",  64'(bus.seg),  {22'd0, {42{1'b1}}});
      chk("abort.done", 64'(bus.done), 64'd0);
      dcnt = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (bus.done) dcnt++;
      end
      chk("abort.nodone", 64'(dcnt), 64'd0);

      // random conversions
      for (int n = 0; n < 30; n++) begin
         case ($urandom_range(0, 3))
            0:       rv = $urandom_range(0, 999);
            1:       rv = $urandom_range(0, 999999);
            2:       rv = $urandom_range(999990, 1000010);
            default: rv = $urandom;
         endcase
         run(rv, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
